uart_tx_fifo: RTL and testbench

Buffered 8N1 UART transmitter producing the serial line consumed by the main controller's RXD input. A small FIFO accepts bytes over a valid/ready handshake. A bit-timing FSM serialises them LSB first with a start bit and a configurable number of stop bits. It runs in the 50 MHz system clock domain and emits frames back-to-back while data is queued.

---
 rtl/uart_tx_fifo.sv | 152 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small FIFO feeds an LSB-first serialiser
// with a start bit and one or two stop bits, frames sent back-to-back.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk50,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
    logic [7:0]    sh, sh_n;
    logic [2:0]    bitcnt, bitcnt_n;
    logic [CW-1:0] baud, baud_n;
    logic          stop_idx, stop_idx_n;
    logic          txd_n, tx_ready_n, busy_n;
    logic          push_c, pop_c, empty_c, bit_end_c;

    assign push_c    = tx_valid && tx_ready;
    assign empty_c   = (wr_ptr == rd_ptr);
    assign bit_end_c = (baud == CW'(CLKS_PER_BIT - 1));

    // FIFO storage needs no reset; occupancy lives entirely in the pointers
    always_ff @(posedge clk50) begin
        if (push_c) begin
            mem[wr_ptr[AW-1:0]] <= tx_data;
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sh       <= '0;
            bitcnt   <= '0;
            baud     <= '0;
            stop_idx <= 1'b0;
            txd      <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            sh       <= sh_n;
            bitcnt   <= bitcnt_n;
            baud     <= baud_n;
            stop_idx <= stop_idx_n;
            txd      <= txd_n;
            tx_ready <= tx_ready_n;
            busy     <= busy_n;
        end
    end

    // Bit-timing FSM; flags are computed from next pointers so they stay registered
    always_comb begin
        state_n    = state;
        sh_n       = sh;
        bitcnt_n   = bitcnt;
        baud_n     = baud;
        stop_idx_n = stop_idx;
        txd_n      = txd;
        pop_c      = 1'b0;

        case (state)
            IDLE: begin
                txd_n = 1'b1;
                if (!empty_c) begin
                    pop_c      = 1'b1;
                    sh_n       = mem[rd_ptr[AW-1:0]];
                    bitcnt_n   = '0;
                    baud_n     = '0;
                    stop_idx_n = 1'b0;
                    txd_n      = 1'b0;
                    state_n    = START;
                end
            end
            START: begin
                if (bit_end_c) begin
                    baud_n  = '0;
                    txd_n   = sh[0];
                    state_n = DATA;
                end else begin
                    baud_n = baud + CW'(1);
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    baud_n   = '0;
                    sh_n     = {1'b0, sh[7:1]};
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        stop_idx_n = 1'b0;
                        txd_n      = 1'b1;
                        state_n    = STOP;
                    end else begin
                        txd_n = sh[1];
                    end
                end else begin
                    baud_n = baud + CW'(1);
                end
            end
            STOP: begin
                if (bit_end_c) begin
                    baud_n = '0;
                    if (stop_idx == 1'(STOP_BITS - 1)) begin
                        // Chain straight into the next start bit when data is queued
                        if (!empty_c) begin
                            pop_c    = 1'b1;
                            sh_n     = mem[rd_ptr[AW-1:0]];
                            bitcnt_n = '0;
                            txd_n    = 1'b0;
                            state_n  = START;
                        end else begin
                            txd_n   = 1'b1;
                            state_n = IDLE;
                        end
                    end else begin
                        stop_idx_n = stop_idx + 1'b1;
                    end
                end else begin
                    baud_n = baud + CW'(1);
                end
            end
            default: begin
                txd_n   = 1'b1;
                state_n = IDLE;
            end
        endcase

        wr_ptr_n   = push_c ? wr_ptr + PW'(1) : wr_ptr;
        rd_ptr_n   = pop_c  ? rd_ptr + PW'(1) : rd_ptr;
        tx_ready_n = ((wr_ptr_n ^ rd_ptr_n) != {1'b1, {AW{1'b0}}});
        busy_n     = (state_n != IDLE) || (wr_ptr_n != rd_ptr_n);
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: cycle-level reference model plus line decoder on a
// 1-stop-bit instance, and directed frame timing on a 2-stop-bit instance.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int F1    = 10 * CPB;

    logic       clk50 = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, txd, busy;

    logic       rst2_n = 1'b0;
    logic [7:0] tx_data2 = '0;
    logic       tx_valid2 = 1'b0;
    logic       tx_ready2, txd2, busy2;

    int checks = 0;
    int errors = 0;

    always #5 clk50 = ~clk50;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk50(clk50), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .txd(txd), .busy(busy)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_dut2 (
        .clk50(clk50), .rst_n(rst2_n), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .txd(txd2), .busy(busy2)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endfunction

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        else if (idx <= 8) return b[idx-1];
        else return 1'b1;
    endfunction

    // Reference model: queue of accepted bytes, one frame at a time on the line
    logic [7:0] m_q[$];
    logic [7:0] m_acc[$];
    logic [7:0] m_cur = '0;
    logic [7:0] m_pend_data = '0;
    logic       m_in = 1'b0;
    logic       m_pend = 1'b0;
    int         m_pos = 0;
    logic       exp_txd, exp_ready, exp_busy;

    always @(negedge clk50) begin
        if (!rst_n) begin
            m_q.delete();
            m_in = 1'b0;
            m_pos = 0;
        end else begin
            if (m_in) begin
                m_pos++;
                if (m_pos == F1) m_in = 1'b0;
            end
            if (!m_in && m_q.size() > 0) begin
                m_cur = m_q.pop_front();
                m_in = 1'b1;
                m_pos = 0;
            end
            if (m_pend) begin
                m_q.push_back(m_pend_data);
                m_acc.push_back(m_pend_data);
            end
        end
        exp_txd   = m_in ? frame_bit(m_cur, m_pos / CPB) : 1'b1;
        exp_ready = (m_q.size() < DEPTH);
        exp_busy  = m_in || (m_q.size() > 0);
        chk("model_txd", {31'b0, txd}, {31'b0, exp_txd});
        chk("model_tx_ready", {31'b0, tx_ready}, {31'b0, exp_ready});
        chk("model_busy", {31'b0, busy}, {31'b0, exp_busy});
        m_pend = rst_n && tx_valid && exp_ready;
        m_pend_data = tx_data;
    end

    // Line decoder: recovers bytes and start-bit times from txd
    logic [7:0] rx_bytes[$];
    int         rx_starts[$];
    logic [7:0] rx_sh = '0;
    logic       rx_act = 1'b0;
    logic       rx_prev = 1'b1;
    int         rx_cnt = 0;
    int         cyc = 0;

    always @(negedge clk50) begin
        cyc++;
        if (!rst_n) begin
            rx_act = 1'b0;
            rx_prev = 1'b1;
        end else begin
            if (!rx_act) begin
                if (rx_prev && !txd) begin
                    rx_act = 1'b1;
                    rx_cnt = 0;
                    rx_starts.push_back(cyc);
                end
            end else begin
                rx_cnt++;
            end
            if (rx_act) begin
                if (rx_cnt >= 2 && (rx_cnt - 2) % CPB == 0 && (rx_cnt - 2) / CPB >= 1
                    && (rx_cnt - 2) / CPB <= 8)
                    rx_sh[(rx_cnt - 2) / CPB - 1] = txd;
                if (rx_cnt == F1 - 1) begin
                    rx_act = 1'b0;
                    rx_bytes.push_back(rx_sh);
                end
            end
            rx_prev = txd;
        end
    end

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy !== 1'b0 || rx_act) && n < budget) begin
            tick();
            n++;
        end
        chk("wait_idle", {31'b0, busy}, 32'd0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
        int         busy_fall;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int n_acc;
        int stop_high;
        logic saw_low;
        logic [7:0] d;

        vecs[0] = '{data: 8'hA5, frame: 10'b1101001010, busy_fall: 41};
        vecs[1] = '{data: 8'h00, frame: 10'b1000000000, busy_fall: 41};
        vecs[2] = '{data: 8'hFF, frame: 10'b1111111110, busy_fall: 41};
        vecs[3] = '{data: 8'hC3, frame: 10'b1110000110, busy_fall: 41};

        // Reset and idle
        repeat (5) tick();
        chk("reset_txd", {31'b0, txd}, 32'd1);
        chk("reset_ready", {31'b0, tx_ready}, 32'd1);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;
        rst2_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (txd !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("idle_100", bad, 32'd0);

        // Single-frame vectors: latency, bit centres, busy fall
        for (int v = 0; v < 4; v++) begin
            wait_idle(200);
            tx_data = vecs[v].data;
            tx_valid = 1'b1;
            tick();
            tx_valid = 1'b0;
            chk("latency_pre", {31'b0, txd}, 32'd1);
            for (int rel = 1; rel <= vecs[v].busy_fall; rel++) begin
                tick();
                if (rel == 1) chk("latency_fall", {31'b0, txd}, 32'd0);
                if ((rel - 1) % CPB == 2 && (rel - 1) / CPB < 10)
                    chk("frame_bit", {31'b0, txd}, {31'b0, vecs[v].frame[(rel - 1) / CPB]});
                if (rel == vecs[v].busy_fall - 1) chk("busy_before_fall", {31'b0, busy}, 32'd1);
                if (rel == vecs[v].busy_fall) chk("busy_fall", {31'b0, busy}, 32'd0);
            end
        end

        // Back-to-back frames
        wait_idle(200);
        rx_bytes.delete();
        rx_starts.delete();
        tx_valid = 1'b1;
        tx_data = 8'h00; tick();
        tx_data = 8'hFF; tick();
        tx_data = 8'h55; tick();
        tx_valid = 1'b0;
        wait_idle(400);
        chk("b2b_count", rx_bytes.size(), 32'd3);
        if (rx_bytes.size() == 3) begin
            chk("b2b_byte0", {24'b0, rx_bytes[0]}, 32'h00);
            chk("b2b_byte1", {24'b0, rx_bytes[1]}, 32'hFF);
            chk("b2b_byte2", {24'b0, rx_bytes[2]}, 32'h55);
            chk("b2b_gap01", rx_starts[1] - rx_starts[0], F1);
            chk("b2b_gap12", rx_starts[2] - rx_starts[1], F1);
        end

        // Back-pressure with incrementing data
        rx_bytes.delete();
        d = 8'h10;
        n_acc = 0;
        saw_low = 1'b0;
        tx_data = d;
        tx_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            automatic logic acc = tx_ready;
            if (!tx_ready) saw_low = 1'b1;
            tick();
            if (acc) begin
                d++;
                n_acc++;
                tx_data = d;
            end
        end
        tx_valid = 1'b0;
        chk("bp_ready_low", {31'b0, saw_low}, 32'd1);
        wait_idle(1000);
        chk("bp_count", rx_bytes.size(), n_acc);
        for (int i = 0; i < rx_bytes.size(); i++)
            chk("bp_stream", {24'b0, rx_bytes[i]}, 32'h10 + i);

        // Randomised traffic against the model's accepted list
        rx_bytes.delete();
        m_acc.delete();
        for (int i = 0; i < 800; i++) begin
            tx_valid = ($urandom_range(0, 9) < 3);
            tx_data = 8'($urandom);
            tick();
        end
        tx_valid = 1'b0;
        wait_idle(5000);
        chk("rand_count", rx_bytes.size(), m_acc.size());
        for (int i = 0; i < rx_bytes.size() && i < m_acc.size(); i++)
            chk("rand_stream", {24'b0, rx_bytes[i]}, {24'b0, m_acc[i]});

        // Two stop bits: 8 high cycles then immediate next start, 44-cycle frames
        tx_data2 = 8'h3C;
        tx_valid2 = 1'b1;
        tick();
        tick();
        tx_valid2 = 1'b0;
        chk("s2_fall", {31'b0, txd2}, 32'd0);
        stop_high = 0;
        for (int off = 1; off <= 88; off++) begin
            tick();
            if (off % CPB == 2 && off / CPB < 10)
                chk("s2_frame_bit", {31'b0, txd2}, {31'b0, frame_bit(8'h3C, off / CPB)});
            if (off >= 36 && off <= 43 && txd2 === 1'b1) stop_high++;
            if (off == 44) chk("s2_next_start", {31'b0, txd2}, 32'd0);
            if (off == 87) chk("s2_busy_before_fall", {31'b0, busy2}, 32'd1);
            if (off == 88) chk("s2_busy_fall", {31'b0, busy2}, 32'd0);
        end
        chk("s2_stop_high", stop_high, 32'd8);

        // Mid-frame reset during data bit 3 with two bytes queued
        wait_idle(200);
        rx_bytes.delete();
        rx_starts.delete();
        tx_valid = 1'b1;
        tx_data = 8'h00; tick();
        tx_data = 8'h81; tick();
        tx_data = 8'h42; tick();
        tx_valid = 1'b0;
        repeat (16) tick();
        chk("mid_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_txd", {31'b0, txd}, 32'd1);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("mid_release_ready", {31'b0, tx_ready}, 32'd1);
        chk("mid_release_busy", {31'b0, busy}, 32'd0);
        repeat (60) tick();
        chk("mid_no_frames", rx_starts.size(), 32'd1);
        chk("mid_no_bytes", rx_bytes.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
